pe_demux: RTL

PE_DEMUX -- requirements
Module: pe_demux

---
 rtl/pe_demux.sv | 113 +++++++++++
 1 files changed

// File: rtl/pe_demux.sv
// pe_demux: routes a signed input stream to one of two independent output FIFOs.
// in_sel picks the destination FIFO; each output port presents its FIFO head with
// valid/ready handshaking and keeps a saturating count of delivered words.
module pe_demux #(
  parameter int W     = 24,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_sel,
  input  logic signed [W-1:0] in_data,
  output logic                in_ready,
  output logic                a_valid,
  output logic signed [W-1:0] a_data,
  input  logic                a_ready,
  output logic [15:0]         a_cnt,
  output logic                b_valid,
  output logic signed [W-1:0] b_data,
  input  logic                b_ready,
  output logic [15:0]         b_cnt
);

  // Pointer width: DEPTH is a power of two, so pointers wrap naturally.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Occupancy must be able to represent DEPTH itself.
  localparam int CW = $clog2(DEPTH + 1);

  // Per-port views, index 0 = port A, index 1 = port B.
  logic [1:0]          out_ready;
  logic [1:0]          out_valid;
  logic [1:0]          fifo_full;
  logic [1:0]          push;
  logic [1:0]          pop;
  logic signed [W-1:0] out_data [2];
  logic [15:0]         out_cnt  [2];

  assign out_ready = {b_ready, a_ready};

  // Readiness depends only on the occupancy of the selected FIFO, never on the
  // downstream ready of the same cycle, so a full FIFO never passes through.
  assign in_ready = rst_n && !fifo_full[in_sel];

  assign a_valid = out_valid[0];
  assign a_data  = out_data[0];
  assign a_cnt   = out_cnt[0];
  assign b_valid = out_valid[1];
  assign b_data  = out_data[1];
  assign b_cnt   = out_cnt[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic signed [W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       occ_q, occ_d;
    logic [15:0]         cnt_q, cnt_d;

    assign fifo_full[gi] = (occ_q == CW'(DEPTH));
    assign out_valid[gi] = (occ_q != '0);
    // in_ready already folds in reset, so nothing is stored while rst_n is low.
    assign push[gi]      = in_valid && in_ready && (in_sel == 1'(gi));
    assign pop[gi]       = rst_n && out_valid[gi] && out_ready[gi];
    // Head is read straight from storage; forced to zero when the FIFO is empty.
    assign out_data[gi]  = out_valid[gi] ? mem_q[rd_ptr_q] : '0;
    assign out_cnt[gi]   = cnt_q;

    // Next-state for pointers, occupancy and the saturating delivery counter.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      cnt_d    = cnt_q;
      if (push[gi]) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop[gi]) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (push[gi] && !pop[gi]) begin
        occ_d = occ_q + CW'(1);
      end else if (!push[gi] && pop[gi]) begin
        occ_d = occ_q - CW'(1);
      end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        occ_q    <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        occ_q    <= occ_d;
        cnt_q    <= cnt_d;
      end
    end

    // Storage write at the tail; contents need no reset because reads are gated by occupancy.
    always_ff @(posedge clk) begin
      if (push[gi]) begin
        mem_q[wr_ptr_q] <= in_data;
      end
    end
  end

endmodule
